unsharp_mask: RTL and testbench

//   Streaming raster-order image sharpener: out = sat(center + gain*(center - blur3x3)).

---
 rtl/unsharp_pkg.sv | 19 +
 rtl/unsharp_mask_line_buffer.sv | 21 ++
 rtl/unsharp_mask.sv | 172 +++++++++++++++++
 tb/tb_unsharp_mask.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/unsharp_pkg.sv
// Shared constants and helpers for the unsharp-mask sharpener.
package unsharp_pkg;

  localparam int unsigned ROUND = 8;
  localparam int unsigned SHIFT = 4;

  localparam int unsigned KERNEL [3][3] = '{'{1, 2, 1},
                                            '{2, 4, 2},
                                            '{1, 2, 1}};

  function automatic int clamp(input int y, input int maxv);
    if (y < 0)
      return 0;
    else if (y > maxv)
      return maxv;
    return y;
  endfunction

endpackage

// File: rtl/unsharp_mask_line_buffer.sv
// One-line delay: the word read at addr_i is the one written DEPTH writes ago.
module line_buffer #(
  parameter int unsigned DEPTH = 256,
  parameter int unsigned WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] addr_i,
  input  logic [WIDTH-1:0]         din_i,
  output logic [WIDTH-1:0]         dout_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[addr_i] <= din_i;
  end

  assign dout_o = mem_q[addr_i];

endmodule

// File: rtl/unsharp_mask.sv
// Streaming 3x3 unsharp mask: out = sat(center + gain*(center - blur3x3)).
module unsharp_mask
  import unsharp_pkg::*;
#(
  parameter int unsigned IMG_WIDTH  = 256,
  parameter int unsigned IMG_HEIGHT = 256,
  parameter int unsigned PIXEL_W    = 8,
  parameter int unsigned GAIN_W     = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [PIXEL_W-1:0] pixel_in,
  input  logic               valid_in,
  input  logic [GAIN_W-1:0]  gain,
  output logic [PIXEL_W-1:0] pixel_out,
  output logic               valid_out
);

  localparam int unsigned CW    = $clog2(IMG_WIDTH);
  localparam int unsigned RW    = $clog2(IMG_HEIGHT);
  localparam int unsigned SUM_W = PIXEL_W + 4;
  localparam int unsigned P_W   = PIXEL_W + GAIN_W + 1;
  localparam int unsigned Y_W   = PIXEL_W + GAIN_W + 2;
  localparam int          PMAX  = (1 << PIXEL_W) - 1;

  logic [CW-1:0] col_q, col_d, cc_q, cc_d;
  logic [RW-1:0] row_q, row_d, cr_q, cr_d;
  logic          primed_q, primed_d;
  logic          win_valid_q, win_valid_d;
  logic          win_border_q, win_border_d;
  logic [PIXEL_W-1:0] win_q [3][3];
  logic [PIXEL_W-1:0] lb0_dout, lb1_dout;

  logic               s1_valid_q, s1_border_q;
  logic [SUM_W-1:0]   s1_sum_q, s1_sum_d;
  logic [PIXEL_W-1:0] s1_center_q;

  logic                  s2_valid_q;
  logic signed [Y_W-1:0] s2_y_q, s2_y_d;

  logic [PIXEL_W-1:0] pixel_out_q, pixel_out_d;
  logic               valid_out_q;

  line_buffer #(.DEPTH(IMG_WIDTH), .WIDTH(PIXEL_W)) u_lb0 (
    .clk    (clk),
    .we_i   (valid_in & rst),
    .addr_i (col_q),
    .din_i  (pixel_in),
    .dout_o (lb0_dout)
  );

  line_buffer #(.DEPTH(IMG_WIDTH), .WIDTH(PIXEL_W)) u_lb1 (
    .clk    (clk),
    .we_i   (valid_in & rst),
    .addr_i (col_q),
    .din_i  (lb0_dout),
    .dout_o (lb1_dout)
  );

  // cc/cr track the window centre, which lags the input by W+1 pixels;
  // their reset value is (W+1) steps before (0,0) so no subtraction is needed.
  always_comb begin
    col_d        = col_q;
    row_d        = row_q;
    cc_d         = cc_q;
    cr_d         = cr_q;
    win_valid_d  = valid_in && (primed_q || (row_q != '0 && col_q != '0));
    primed_d     = primed_q | win_valid_d;
    win_border_d = win_border_q;
    if (valid_in) begin
      if (col_q == CW'(IMG_WIDTH - 1)) begin
        col_d = '0;
        row_d = (row_q == RW'(IMG_HEIGHT - 1)) ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
      if (cc_q == CW'(IMG_WIDTH - 1)) begin
        cc_d = '0;
        cr_d = (cr_q == RW'(IMG_HEIGHT - 1)) ? '0 : cr_q + 1'b1;
      end else begin
        cc_d = cc_q + 1'b1;
      end
      win_border_d = (cr_q == '0) || (cr_q == RW'(IMG_HEIGHT - 1)) ||
                     (cc_q == '0) || (cc_q == CW'(IMG_WIDTH - 1));
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      col_q        <= '0;
      row_q        <= '0;
      cc_q         <= CW'(IMG_WIDTH - 1);
      cr_q         <= RW'(IMG_HEIGHT - 2);
      primed_q     <= 1'b0;
      win_valid_q  <= 1'b0;
      win_border_q <= 1'b0;
    end else begin
      col_q        <= col_d;
      row_q        <= row_d;
      cc_q         <= cc_d;
      cr_q         <= cr_d;
      primed_q     <= primed_d;
      win_valid_q  <= win_valid_d;
      win_border_q <= win_border_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int unsigned r = 0; r < 3; r++)
        for (int unsigned c = 0; c < 3; c++)
          win_q[r][c] <= '0;
    end else if (valid_in) begin
      for (int unsigned r = 0; r < 3; r++) begin
        win_q[r][0] <= win_q[r][1];
        win_q[r][1] <= win_q[r][2];
      end
      win_q[0][2] <= lb1_dout;
      win_q[1][2] <= lb0_dout;
      win_q[2][2] <= pixel_in;
    end
  end

  always_comb begin
    int unsigned acc;
    acc = 0;
    for (int unsigned r = 0; r < 3; r++)
      for (int unsigned c = 0; c < 3; c++)
        acc = acc + KERNEL[r][c] * 32'(win_q[r][c]);
    s1_sum_d = SUM_W'(acc);
  end

  always_comb begin
    logic [PIXEL_W-1:0]        blur;
    logic signed [PIXEL_W:0]   d;
    logic signed [P_W-1:0]     p;
    logic signed [PIXEL_W:0]   ctr;
    ctr    = $signed({1'b0, s1_center_q});
    blur   = PIXEL_W'((32'(s1_sum_q) + ROUND) >> SHIFT);
    d      = ctr - $signed({1'b0, blur});
    p      = P_W'(d) * P_W'($signed({1'b0, gain}));
    s2_y_d = s1_border_q ? Y_W'(ctr) : Y_W'(p) + Y_W'(ctr);
  end

  assign pixel_out_d = PIXEL_W'(clamp(int'(s2_y_q), PMAX));

  always_ff @(posedge clk) begin
    if (!rst) begin
      s1_valid_q  <= 1'b0;
      s1_border_q <= 1'b0;
      s1_sum_q    <= '0;
      s1_center_q <= '0;
      s2_valid_q  <= 1'b0;
      s2_y_q      <= '0;
      pixel_out_q <= '0;
      valid_out_q <= 1'b0;
    end else begin
      s1_valid_q  <= win_valid_q;
      s1_border_q <= win_border_q;
      s1_sum_q    <= s1_sum_d;
      s1_center_q <= win_q[1][1];
      s2_valid_q  <= s1_valid_q;
      s2_y_q      <= s2_y_d;
      valid_out_q <= s2_valid_q;
      if (s2_valid_q) pixel_out_q <= pixel_out_d;
    end
  end

  assign pixel_out = pixel_out_q;
  assign valid_out = valid_out_q;

endmodule

// File: tb/tb_unsharp_mask.sv
// Directed/random bench for unsharp_mask against a frame-level reference model.
module tb_unsharp_mask;

  localparam int W  = 8;
  localparam int H  = 8;
  localparam int WH = W * H;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] pixel_in = '0;
  logic       valid_in = 1'b0;
  logic [7:0] gain = '0;
  logic [7:0] pixel_out;
  logic       valid_out;

  unsharp_mask #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .PIXEL_W(8), .GAIN_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .pixel_in  (pixel_in),
    .valid_in  (valid_in),
    .gain      (gain),
    .pixel_out (pixel_out),
    .valid_out (valid_out)
  );

  always #5 clk = ~clk;

  typedef struct { int val; int due; } exp_t;

  int   errors = 0;
  int   checks = 0;
  int   ecount = 0;
  int   img[$];
  int   stream[$];
  int   got[$];
  exp_t exp_q[$];

  task automatic chk(input string tag, input int obs, input int expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  // Expected output for the k-th pixel accepted since reset, from image rules.
  function automatic int model(input int k);
    int r, c, ctr, s, blur, y;
    r   = (k / W) % H;
    c   = k % W;
    ctr = stream[k];
    if (r == 0 || r == H - 1 || c == 0 || c == W - 1) return ctr;
    s = 0;
    for (int dr = -1; dr <= 1; dr++)
      for (int dc = -1; dc <= 1; dc++)
        s += (2 - (dr < 0 ? -dr : dr)) * (2 - (dc < 0 ? -dc : dc)) * stream[k + dr * W + dc];
    blur = (s + 8) / 16;
    y    = ctr + (ctr - blur) * int'(gain);
    if (y < 0) return 0;
    if (y > 255) return 255;
    return y;
  endfunction

  task automatic drive(input logic v, input int pix);
    pixel_in = 8'(pix);
    valid_in = v;
    @(posedge clk);
    ecount++;
    if (v) begin
      stream.push_back(pix);
      if (stream.size() >= W + 2)
        exp_q.push_back('{model(stream.size() - 1 - (W + 1)), ecount + 3});
    end
    #1;
    if (exp_q.size() != 0 && exp_q[0].due == ecount) begin
      chk("valid_out_due", int'(valid_out), 1);
      chk("pixel_out", int'(pixel_out), exp_q[0].val);
      got.push_back(int'(pixel_out));
      void'(exp_q.pop_front());
    end else begin
      chk("valid_out_idle", int'(valid_out), 0);
    end
  endtask

  task automatic do_reset();
    rst      = 1'b0;
    valid_in = 1'b0;
    @(posedge clk);
    ecount++;
    #1;
    chk("rst_valid_out", int'(valid_out), 0);
    chk("rst_pixel_out", int'(pixel_out), 0);
    stream.delete();
    exp_q.delete();
    got.delete();
    rst = 1'b1;
  endtask

  task automatic run_img(input bit gaps);
    int i;
    int budget;
    i = 0;
    budget = 0;
    while (i < img.size() && budget < 2000) begin
      budget++;
      if (gaps && $urandom_range(0, 2) == 0) begin
        drive(1'b0, 0);
      end else begin
        drive(1'b1, img[i]);
        i++;
      end
    end
    chk("stream_budget", i, img.size());
    repeat (6) drive(1'b0, 0);
    chk("pending_empty", exp_q.size(), 0);
  endtask

  task automatic fill_const(input int v);
    img.delete();
    for (int i = 0; i < 2 * WH; i++) img.push_back(v);
  endtask

  task automatic fill_rand();
    img.delete();
    for (int i = 0; i < 2 * WH; i++) img.push_back(int'($urandom_range(0, 255)));
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;

    gain = 8'd2;
    do_reset();
    fill_const(100);
    run_img(1'b0);
    chk("flat_count", got.size(), 2 * WH - (W + 1));
    chk("flat_first", got[0], 100);

    gain = 8'd1;
    do_reset();
    fill_const(100);
    img[3 * W + 3] = 120;
    img[WH + 3 * W + 3] = 120;
    run_img(1'b0);
    chk("spot_33", got[3 * W + 3], 135);
    chk("spot_34", got[3 * W + 4], 97);
    chk("spot_44", got[4 * W + 4], 99);
    chk("spot_22", got[2 * W + 2], 100 + (100 - ((1600 + 20 + 8) / 16)));

    do_reset();
    fill_const(0);
    img[3 * W + 3] = 255;
    img[WH + 3 * W + 3] = 255;
    run_img(1'b0);
    chk("sat_hi_33", got[3 * W + 3], 255);
    chk("sat_lo_34", got[3 * W + 4], 0);

    gain = 8'd0;
    do_reset();
    fill_rand();
    run_img(1'b0);
    for (int k = 0; k < got.size(); k++) chk("gain0_passthru", got[k], img[k]);

    gain = 8'd2;
    do_reset();
    fill_rand();
    run_img(1'b0);
    for (int k = 0; k < got.size(); k++) begin
      if ((k / W) % H == 0 || (k / W) % H == H - 1 || k % W == 0 || k % W == W - 1)
        chk("border_passthru", got[k], img[k]);
    end

    do_reset();
    fill_rand();
    run_img(1'b1);
    chk("gaps_count", got.size(), 2 * WH - (W + 1));

    gain = 8'd3;
    do_reset();
    fill_rand();
    for (int i = 0; i < 3 * W + 5; i++) drive(1'b1, img[i]);
    do_reset();
    fill_rand();
    run_img(1'b0);
    chk("post_rst_count", got.size(), 2 * WH - (W + 1));

    gain = 8'd255;
    do_reset();
    fill_rand();
    run_img(1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
